// File: rtl/gf8_pkg.sv
// Shared constants and state encoding for the GF(2^8) divider and its multiplier.
package gf8_pkg;

   localparam logic [7:0] POLY_DEFAULT = 8'h1B;

   // Index of the final multiply (r * a) in the exponentiation sequence
   localparam logic [3:0] LAST_STEP = 4'd13;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/gf8_mul_comb.sv
// Combinational GF(2^8) multiply: carry-less 15-bit product, then reduction mod x^8 + POLY.
module gf8_mul_comb
   import gf8_pkg::*;
#(
   parameter logic [7:0] POLY = POLY_DEFAULT
) (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   output logic [7:0] o_p
);

   logic [14:0] w_prod;

   always_comb begin
      w_prod = '0;
      for (int i = 0; i < 8; i++) begin
         if (i_b[i]) begin
            w_prod = w_prod ^ (15'(i_a) << i);
         end
      end
      // Fold x^i down as x^(i-8) * POLY, highest term first
      for (int i = 14; i >= 8; i--) begin
         if (w_prod[i]) begin
            w_prod = w_prod ^ ({7'd0, POLY} << (i - 8)) ^ (15'd1 << i);
         end
      end
      o_p = w_prod[7:0];
   end

endmodule

// File: rtl/gf8_div_seq.sv
// Sequential GF(2^8) divider: q = a * b^-1, with b^-1 = b^254 built by square-and-multiply
// through one shared multiplier. Valid/ready handshake on operands and result.
module gf8_div_seq
   import gf8_pkg::*;
#(
   parameter logic [7:0] POLY = POLY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] q,
   output logic       div_zero,
   output logic       busy
);

   state_e     r_state;
   state_e     w_state_next;
   logic [3:0] r_step;
   logic [7:0] r_a;
   logic [7:0] r_b;
   logic [7:0] r_r;
   logic [7:0] r_q;
   logic       r_div_zero;
   logic [7:0] w_mul_y;
   logic [7:0] w_mul_p;
   logic       w_last;

   assign w_last = (r_step == LAST_STEP);

   // Even steps square, odd steps multiply by b; the last step applies the dividend
   always_comb begin
      w_mul_y = r_r;
      if (w_last) begin
         w_mul_y = r_a;
      end else if (r_step[0]) begin
         w_mul_y = r_b;
      end
   end

   gf8_mul_comb #(
      .POLY (POLY)
   ) u_mul (
      .i_a (r_r),
      .i_b (w_mul_y),
      .o_p (w_mul_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (in_valid) begin
               w_state_next = (b == 8'd0) ? StDone : StCalc;
            end
         end
         StCalc: begin
            if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         StIdle: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         StDone:  out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_step     <= 4'd0;
         r_a        <= 8'd0;
         r_b        <= 8'd0;
         r_r        <= 8'd0;
         r_q        <= 8'd0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (in_valid) begin
                  r_a    <= a;
                  r_b    <= b;
                  r_r    <= b;
                  r_step <= 4'd0;
                  if (b == 8'd0) begin
                     r_q        <= 8'd0;
                     r_div_zero <= 1'b1;
                  end
               end
            end
            StCalc: begin
               if (w_last) begin
                  r_q        <= w_mul_p;
                  r_div_zero <= 1'b0;
                  r_step     <= 4'd0;
               end else begin
                  r_r    <= w_mul_p;
                  r_step <= r_step + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign q        = r_q;
   assign div_zero = r_div_zero;

endmodule
